// File: rtl/alu32.sv
// alu32: 32-bit MIPS-style integer ALU with a registered result and zero flag.
// The result and zero flag are captured together each rising clock edge.
// They feed the next pipeline stage directly from the register.
module alu32 (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        z
);

  // aluc[1:0] picks the operation group.
  // aluc[2] picks the variant within the group.
  // aluc[3] only matters for the right-shift pair (SRL vs SRA).
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_XOR = 3'b010,
    OP_SLL = 3'b011,
    OP_SUB = 3'b100,
    OP_OR  = 3'b101,
    OP_LUI = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  op_t         op;
  logic [4:0]  shamt;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] next_r;

  assign op    = op_t'(aluc[2:0]);
  assign shamt = a[4:0];

  // Arithmetic and shift results; carries/borrows simply fall off the top.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    sll_res = b << shamt;
    srl_res = b >> shamt;
    sra_res = $signed(b) >>> shamt;
  end

  // Operation select; z is derived from this same value so r and z always agree.
  always_comb begin
    next_r = 32'h0000_0000;
    unique case (op)
      OP_ADD: next_r = sum;
      OP_SUB: next_r = diff;
      OP_AND: next_r = a & b;
      OP_OR:  next_r = a | b;
      OP_XOR: next_r = a ^ b;
      OP_LUI: next_r = {b[15:0], 16'h0000};
      OP_SLL: next_r = sll_res;
      OP_SHR: next_r = aluc[3] ? sra_res : srl_res;
      default: next_r = 32'h0000_0000;
    endcase
  end

  // Output register; reset clears the result and reports zero without waiting for a clock.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r <= 32'h0000_0000;
      z <= 1'b1;
    end else begin
      r <= next_r;
      z <= (next_r == 32'h0000_0000);
    end
  end

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed-vector bench for alu32 with hand-computed expected results.
module tb_alu32;

  logic        clk;
  logic        clrn;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        z;

  int error_count;
  int check_count;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b0100;
  localparam logic [3:0] AND_ = 4'b0001;
  localparam logic [3:0] OR_  = 4'b0101;
  localparam logic [3:0] XOR_ = 4'b0010;
  localparam logic [3:0] LUI  = 4'b0110;
  localparam logic [3:0] SLL  = 4'b0011;
  localparam logic [3:0] SLL2 = 4'b1011;
  localparam logic [3:0] SRL  = 4'b0111;
  localparam logic [3:0] SRA  = 4'b1111;

  alu32 dut (
    .clk  (clk),
    .clrn (clrn),
    .a    (a),
    .b    (b),
    .aluc (aluc),
    .r    (r),
    .z    (z)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Drive one operation at the falling edge, then check r and z just after the rising edge.
  task automatic apply_stimulus(input string tag, input logic [31:0] av,
                                input logic [31:0] bv, input logic [3:0] op,
                                input logic [31:0] exp_r);
    @(negedge clk);
    a    = av;
    b    = bv;
    aluc = op;
    @(posedge clk);
    #1;
    check_output({tag, ".r"}, r, exp_r);
    check_output({tag, ".z"}, {31'b0, z}, {31'b0, exp_r == 32'h0});
  endtask

  initial begin
    error_count = 0;
    check_count = 0;
    a    = 32'h0;
    b    = 32'h0;
    aluc = ADD;
    clrn = 1'b0;

    // Initial reset across a couple of edges, then release mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_r", r, 32'h0);
    check_output("reset_z", {31'b0, z}, 32'h1);
    @(negedge clk);
    clrn = 1'b1;

    // Arithmetic
    apply_stimulus("add_1_2",   32'h0000_0001, 32'h0000_0002, ADD, 32'h0000_0003);
    apply_stimulus("sub_1_2",   32'h0000_0001, 32'h0000_0002, SUB, 32'hffff_ffff);
    apply_stimulus("sub_equal", 32'hffff_ffff, 32'hffff_ffff, SUB, 32'h0000_0000);
    apply_stimulus("add_wrap",  32'hffff_ffff, 32'hffff_ffff, ADD, 32'hffff_fffe);

    // Logic and LUI
    apply_stimulus("and",  32'hcccc_cccc, 32'haaaa_aaaa, AND_, 32'h8888_8888);
    apply_stimulus("or",   32'hcccc_cccc, 32'haaaa_aaaa, OR_,  32'heeee_eeee);
    apply_stimulus("xor",  32'h3333_3333, 32'hff00_5555, XOR_, 32'hcc33_6666);
    apply_stimulus("lui",  32'h3333_3333, 32'hff00_5555, LUI,  32'h5555_0000);
    apply_stimulus("lui_zero", 32'hffff_ffff, 32'hffff_0000, LUI, 32'h0000_0000);

    // Shifts, including amount 0, amount 31 and ignored upper bits of a
    apply_stimulus("sll_15",    32'h0000_000f, 32'hffff_ffff, SLL,  32'hffff_8000);
    apply_stimulus("sll_alt",   32'h0000_000f, 32'hffff_ffff, SLL2, 32'hffff_8000);
    apply_stimulus("srl_15",    32'h0000_000f, 32'hffff_ffff, SRL,  32'h0001_ffff);
    apply_stimulus("sra_pos",   32'h0000_0010, 32'h7f00_0000, SRA,  32'h0000_7f00);
    apply_stimulus("sra_neg",   32'h0000_0010, 32'hffff_ff00, SRA,  32'hffff_ffff);
    apply_stimulus("srl_0",     32'hffff_ffe0, 32'h8000_0000, SRL,  32'h8000_0000);
    apply_stimulus("srl_31",    32'h0000_001f, 32'h8000_0000, SRL,  32'h0000_0001);
    apply_stimulus("sra_31",    32'h0000_001f, 32'h8000_0000, SRA,  32'hffff_ffff);
    apply_stimulus("sll_31",    32'h0000_001f, 32'h0000_0003, SLL,  32'h8000_0000);
    apply_stimulus("sll_hi_a",  32'hffff_ffe1, 32'h0000_0001, SLL,  32'h0000_0002);

    // Inputs changing between edges must not reach the outputs before the next edge.
    apply_stimulus("pre_hold", 32'h0000_0001, 32'h0000_0002, ADD, 32'h0000_0003);
    @(negedge clk);
    a    = 32'h1234_5678;
    b    = 32'h1234_5678;
    aluc = SUB;
    #2;
    check_output("hold_r", r, 32'h0000_0003);
    check_output("hold_z", {31'b0, z}, 32'h0);
    a = 32'h0000_0010;
    b = 32'h0000_0020;
    aluc = OR_;
    @(posedge clk);
    #1;
    check_output("hold_next_r", r, 32'h0000_0030);

    // Asynchronous reset mid-cycle, held across an edge, then released.
    #1;
    clrn = 1'b0;
    #1;
    check_output("async_rst_r", r, 32'h0);
    check_output("async_rst_z", {31'b0, z}, 32'h1);
    a    = 32'h0000_0005;
    b    = 32'h0000_0006;
    aluc = ADD;
    @(posedge clk);
    #1;
    check_output("rst_hold_r", r, 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check_output("rst_release_r", r, 32'h0);
    apply_stimulus("post_rst_add", 32'h0000_0001, 32'h0000_0002, ADD, 32'h0000_0003);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
